prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader sitting directly upstream of the instruction and data memories. It consumes a byte stream from the UART receiver and assembles each instruction image into 128-bit lines for the instruction memory. It also assembles each data image into 32-bit words for the data memory. While it runs, the pipeline is held in reset; its done flag releases the core.

## Interface
Parameters:
- DMEM_BASE, 32'h0, byte address of the first data word written.
- IMEM_MAX_BYTES, 8192, largest accepted instruction image (9-bit line index × 16).
- DMEM_MAX_BYTES, 8192, largest accepted data image.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset_x  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid. No backpressure; a byte may arrive every cycle.
- ADDR  out  32  byte address of current write (imem uses [12:4], dmem uses [31:2]).
- DATA  out  128  write data; dmem word is DATA[127:96].
- WE_128  out  1  instruction-memory line write strobe.
- WE_32  out  1  data-memory word write strobe.
- DONE  out  1  load complete, sticky until reset.
- ERR  out  1  malformed header, sticky until reset.

## Operation
- Stream format, all little-endian:
  - 4-byte ISIZE.
  - 4-byte DSIZE.
  - ISIZE instruction bytes.
  - DSIZE data bytes.
- States: HDR_I → HDR_D → IMEM → DMEM → FIN; ERROR reachable from HDR_D.
- HDR_I/HDR_D: 2-bit byte counter. Each byte shifts into a 32-bit header register from the top, so byte k lands at [8k+7:8k].
- Header check on the 4th DSIZE byte:
  - ISIZE[3:0]≠0, DSIZE[1:0]≠0, ISIZE>IMEM_MAX_BYTES or DSIZE>DMEM_MAX_BYTES → ERROR.
  - Otherwise → IMEM if ISIZE≠0, else DMEM if DSIZE≠0, else FIN.
- Shared shift register in IMEM and DMEM: every accepted byte does DATA ← {rx_data, DATA[127:8]}.
  - After 16 bytes, byte i of the line is at DATA[8i+7:8i].
  - After 4 bytes, the word is at DATA[127:96], little-endian.
- IMEM: 4-bit in-line counter.
  - On the 16th byte, WE_128 is registered high for the next cycle. ADDR holds the line address, starting at 0 and advancing by 16 after each write.
  - The last line moves the state to DMEM, or to FIN if DSIZE=0.
- DMEM: 2-bit in-word counter.
  - On the 4th byte, WE_32 is registered high. ADDR starts at DMEM_BASE and advances by 4.
  - The last word moves the state to FIN.
- Remaining-byte counters are 32 bits and load from ISIZE/DSIZE. Exact equality to zero ends a segment; no wrap is possible because the header check enforces the limits.
- FIN and ERROR: rx_valid is ignored; state is held until reset.
- Asserting reset_x at any time, mid-line included, aborts the load.
  - All state returns to HDR_I and outputs return to reset values.
  - Partial lines are discarded; memory writes already issued are not undone.

## Timing
- Reset values: ADDR=0, DATA=0, WE_128=0, WE_32=0, DONE=0, ERR=0, state HDR_I.
- Write latency: the strobe is high for exactly one cycle, in the cycle after the edge that accepts the completing byte. ADDR and DATA are stable and registered in that cycle.
- Back-to-back bytes: a byte arriving during a strobe cycle shifts DATA at the end of that cycle. The memory samples the old, complete DATA on the same edge, so no data is lost. ADDR increments on that same edge.
- WE_128 and WE_32 are never high together.
- DONE rises one cycle after the final write strobe. With ISIZE=DSIZE=0, it rises one cycle after the 8th header byte.
- ERR rises one cycle after the 8th header byte. DONE then never rises.

## Test plan
- Reset: hold reset_x=0 while toggling rx_valid → all outputs 0; release reset_x → outputs still 0 until the first byte.
- Nominal load: ISIZE=32, DSIZE=8, payload bytes 0x00..0x27, one every 3 cycles →
  - WE_128 at ADDR 0x0, DATA=0x0f0e…0100, then at 0x10 with 0x1f1e…1110.
  - WE_32 at ADDR 0x0, DATA[127:96]=0x23222120, then at 0x4 with 0x27262524.
  - DONE one cycle after the last strobe; exactly 4 strobes in total.
- Back-to-back: the same stream with rx_valid high every cycle → identical writes; each strobe one cycle after its completing byte; DONE follows.
- Empty images: ISIZE=0, DSIZE=0 → no strobes; DONE one cycle after the 8th byte.
- Errors, each → ERR=1, DONE=0, no strobes, later bytes ignored:
  - ISIZE=20.
  - DSIZE=6.
  - ISIZE=8208.
- Mid-line reset: pull reset_x low after 7 instruction bytes, then resend a full ISIZE=16, DSIZE=0 stream → a single WE_128 at ADDR 0 with the new bytes, then DONE.

Source files
------------

// File: rtl/prog_loader.sv
// ============================================================================
//  Module      : prog_loader
//  Description : Boot-time loader. Turns a UART byte stream (ISIZE, DSIZE,
//                instruction image, data image) into 128-bit imem line writes
//                and 32-bit dmem word writes, then raises DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader #(
    parameter logic [31:0] DMEM_BASE      = 32'h0,
    parameter int unsigned IMEM_MAX_BYTES = 8192,
    parameter int unsigned DMEM_MAX_BYTES = 8192
) (
    input  logic         clk,
    input  logic         reset_x,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [31:0]  ADDR,
    output logic [127:0] DATA,
    output logic         WE_128,
    output logic         WE_32,
    output logic         DONE,
    output logic         ERR
);

    localparam logic [2:0] S_HDR_I = 3'd0;
    localparam logic [2:0] S_HDR_D = 3'd1;
    localparam logic [2:0] S_IMEM  = 3'd2;
    localparam logic [2:0] S_DMEM  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam logic [31:0] C_IMEM_MAX = 32'(IMEM_MAX_BYTES);
    localparam logic [31:0] C_DMEM_MAX = 32'(DMEM_MAX_BYTES);

    logic [2:0]  r_state;
    logic [1:0]  r_hdr_cnt;
    logic [23:0] r_hdr;
    logic [31:0] r_isize;
    logic [31:0] r_dsize;
    logic [31:0] r_remain;
    logic [3:0]  r_byte_cnt;

    logic [31:0]  w_hdr_word;
    logic         w_hdr_bad;
    logic [31:0]  w_remain_dec;
    logic [127:0] w_shift;

    // Header bytes enter from the top so byte k ends up at [8k+7:8k]
    assign w_hdr_word   = {rx_data, r_hdr};
    assign w_hdr_bad    = (r_isize[3:0] != 4'd0) || (w_hdr_word[1:0] != 2'd0) ||
                          (r_isize > C_IMEM_MAX) || (w_hdr_word > C_DMEM_MAX);
    assign w_remain_dec = r_remain - 32'd1;
    assign w_shift      = {rx_data, DATA[127:8]};

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_state    <= S_HDR_I;
            r_hdr_cnt  <= 2'd0;
            r_hdr      <= 24'd0;
            r_isize    <= 32'd0;
            r_dsize    <= 32'd0;
            r_remain   <= 32'd0;
            r_byte_cnt <= 4'd0;
            ADDR       <= 32'd0;
            DATA       <= 128'd0;
            WE_128     <= 1'b0;
            WE_32      <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            WE_128 <= 1'b0;
            WE_32  <= 1'b0;

            // Address advances on the edge that closes a strobe cycle
            if (WE_128) begin
                ADDR <= (r_state == S_DMEM) ? DMEM_BASE : ADDR + 32'd16;
            end else if (WE_32) begin
                ADDR <= ADDR + 32'd4;
            end

            if (r_state == S_FIN) begin
                DONE <= 1'b1;
            end

            case (r_state)
                S_HDR_I: begin
                    if (rx_valid) begin
                        r_hdr     <= w_hdr_word[31:8];
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        if (r_hdr_cnt == 2'd3) begin
                            r_isize <= w_hdr_word;
                            r_state <= S_HDR_D;
                        end
                    end
                end

                S_HDR_D: begin
                    if (rx_valid) begin
                        r_hdr     <= w_hdr_word[31:8];
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        if (r_hdr_cnt == 2'd3) begin
                            r_dsize <= w_hdr_word;
                            if (w_hdr_bad) begin
                                r_state <= S_ERROR;
                                ERR     <= 1'b1;
                            end else if (r_isize != 32'd0) begin
                                r_state  <= S_IMEM;
                                r_remain <= r_isize;
                            end else if (w_hdr_word != 32'd0) begin
                                r_state  <= S_DMEM;
                                r_remain <= w_hdr_word;
                                ADDR     <= DMEM_BASE;
                            end else begin
                                r_state <= S_FIN;
                                DONE    <= 1'b1;
                            end
                        end
                    end
                end

                S_IMEM: begin
                    if (rx_valid) begin
                        DATA       <= w_shift;
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        r_remain   <= w_remain_dec;
                        if (r_byte_cnt == 4'hF) begin
                            WE_128 <= 1'b1;
                        end
                        if (w_remain_dec == 32'd0) begin
                            r_byte_cnt <= 4'd0;
                            if (r_dsize != 32'd0) begin
                                r_state  <= S_DMEM;
                                r_remain <= r_dsize;
                            end else begin
                                r_state <= S_FIN;
                            end
                        end
                    end
                end

                S_DMEM: begin
                    if (rx_valid) begin
                        DATA       <= w_shift;
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        r_remain   <= w_remain_dec;
                        if (r_byte_cnt[1:0] == 2'b11) begin
                            WE_32 <= 1'b1;
                        end
                        if (w_remain_dec == 32'd0) begin
                            r_state <= S_FIN;
                        end
                    end
                end

                default: begin
                    // FIN and ERROR hold until reset; rx_valid is ignored
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader with a stream-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

    localparam logic [31:0] C_BASE = 32'h0;
    localparam int          C_NEVER = 1 << 30;

    logic         clk = 1'b0;
    logic         reset_x = 1'b0;
    logic [7:0]   rx_data = 8'd0;
    logic         rx_valid = 1'b0;
    logic [31:0]  ADDR;
    logic [127:0] DATA;
    logic         WE_128;
    logic         WE_32;
    logic         DONE;
    logic         ERR;

    prog_loader #(
        .DMEM_BASE      (C_BASE),
        .IMEM_MAX_BYTES (8192),
        .DMEM_MAX_BYTES (8192)
    ) dut (
        .clk      (clk),
        .reset_x  (reset_x),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .ADDR     (ADDR),
        .DATA     (DATA),
        .WE_128   (WE_128),
        .WE_32    (WE_32),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] strm[$];
    int  isz;
    int  dsz;
    bit  hdr_ok;
    int  step_no;
    int  fin_step;
    int  err_step;
    int  got_strobes;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stream model: header, ISIZE + DSIZE payload bytes (if legal), then junk
    task automatic prep(input int i_sz, input int d_sz, input bit counting);
        int n;
        isz    = i_sz;
        dsz    = d_sz;
        hdr_ok = (i_sz % 16 == 0) && (d_sz % 4 == 0) && (i_sz <= 8192) && (d_sz <= 8192);
        strm.delete();
        for (int k = 0; k < 4; k++) strm.push_back(8'((i_sz >> (8 * k)) & 255));
        for (int k = 0; k < 4; k++) strm.push_back(8'((d_sz >> (8 * k)) & 255));
        n = hdr_ok ? (i_sz + d_sz) : 0;
        for (int k = 0; k < n; k++) strm.push_back(counting ? 8'(k) : 8'($urandom));
        for (int k = 0; k < 8; k++) strm.push_back(8'($urandom));
        step_no     = 0;
        fin_step    = C_NEVER;
        err_step    = C_NEVER;
        got_strobes = 0;
    endtask

    // One clock edge; p >= 0 sends stream byte p, p < 0 is an idle cycle
    task automatic step(input int p);
        bit           e128;
        bit           e32;
        logic [31:0]  ea;
        logic [127:0] ed;
        int           q;
        e128 = 1'b0;
        e32  = 1'b0;
        ea   = 32'd0;
        ed   = 128'd0;
        @(negedge clk);
        rx_valid = (p >= 0);
        rx_data  = (p >= 0) ? strm[p] : 8'($urandom);
        @(posedge clk);
        #1;
        step_no++;
        if (p >= 0 && hdr_ok) begin
            q = p - 8;
            if (q >= 0 && q < isz && q % 16 == 15) begin
                e128 = 1'b1;
                ea   = 32'(q - 15);
                for (int i = 0; i < 16; i++) ed[8*i +: 8] = strm[p - 15 + i];
            end else if (q >= isz && q < isz + dsz && (q - isz) % 4 == 3) begin
                e32 = 1'b1;
                ea  = C_BASE + 32'(q - isz - 3);
                for (int i = 0; i < 4; i++) ed[96 + 8*i +: 8] = strm[p - 3 + i];
            end
            if (isz + dsz > 0 && p == 8 + isz + dsz - 1) fin_step = step_no + 1;
            if (isz + dsz == 0 && p == 7) fin_step = step_no;
        end
        if (p == 7 && !hdr_ok) err_step = step_no;
        chk("we128", {127'd0, WE_128}, {127'd0, e128});
        chk("we32", {127'd0, WE_32}, {127'd0, e32});
        if (e128 || e32) chk("addr", {96'd0, ADDR}, {96'd0, ea});
        if (e128) chk("line", DATA, ed);
        if (e32) chk("word", {96'd0, DATA[127:96]}, {96'd0, ed[127:96]});
        chk("done", {127'd0, DONE}, {127'd0, (step_no >= fin_step)});
        chk("err", {127'd0, ERR}, {127'd0, (step_no >= err_step)});
        if (WE_128 || WE_32) got_strobes++;
    endtask

    task automatic send(input int nbytes, input int gap);
        int g;
        for (int p = 0; p < nbytes; p++) begin
            step(p);
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int k = 0; k < g; k++) step(-1);
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        #2;
        reset_x = 1'b0;
        #1;
        chk("rst_async", {WE_128, WE_32, DONE, ERR, ADDR, DATA},
            {4'd0, 32'd0, 128'd0});
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            @(posedge clk);
            #1;
            chk("rst_hold", {WE_128, WE_32, DONE, ERR, ADDR, DATA},
                {4'd0, 32'd0, 128'd0});
        end
        @(negedge clk);
        rx_valid = 1'b0;
        reset_x  = 1'b1;
    endtask

    task automatic run_stream(input int i_sz, input int d_sz, input int gap, input bit counting);
        int exp_n;
        prep(i_sz, d_sz, counting);
        send(strm.size(), gap);
        for (int k = 0; k < 3; k++) step(-1);
        exp_n = hdr_ok ? (i_sz / 16 + d_sz / 4) : 0;
        chk("nstrobes", 128'(got_strobes), 128'(exp_n));
        chk("final", {126'd0, DONE, ERR}, {126'd0, hdr_ok, !hdr_ok});
        do_reset(2);
    endtask

    initial begin
        prep(0, 0, 1'b0);
        do_reset(5);
        chk("post_rst", {WE_128, WE_32, DONE, ERR, ADDR, DATA}, {4'd0, 32'd0, 128'd0});
        for (int k = 0; k < 3; k++) step(-1);

        run_stream(32, 8, 2, 1'b1);
        run_stream(32, 8, 0, 1'b1);
        run_stream(0, 0, 0, 1'b0);
        run_stream(20, 8, 0, 1'b0);
        run_stream(16, 6, 1, 1'b0);
        run_stream(8208, 0, 0, 1'b0);
        run_stream(16, 8196, 0, 1'b0);
        run_stream(0, 12, -1, 1'b0);

        // Abort mid-line, then a fresh load must start from line 0
        prep(16, 0, 1'b0);
        send(8 + 7, 0);
        do_reset(3);
        run_stream(16, 0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            run_stream(16 * int'($urandom_range(0, 6)), 4 * int'($urandom_range(0, 8)), -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
